// File: rtl/cbb_rs_multimode.sv
// cbb_rs_multimode
//   Valid/ready register slice for a point-to-point stream link. P_MODE
//   selects how much of the handshake is registered:
//     0 bypass  : wires only, no state
//     1 forward : registered mst_o_valid/mst_o_data, ready is combinational
//     2 backward: registered slv_o_ready with a one-entry skid buffer
//     3 full    : two-entry circular buffer, every handshake output registered
//   Modes 1-3 add occupancy reporting (o_level) and a synchronous flush.
//
// Ports
//   i_clk        sole clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_flush      synchronous flush, discards all stored beats (modes 1-3)
//   slv_i_valid  upstream beat valid
//   slv_i_data   upstream payload
//   slv_o_ready  slice can accept a beat
//   mst_o_valid  downstream beat valid
//   mst_o_data   downstream payload
//   mst_i_ready  downstream accepts a beat
//   o_level      beats currently stored, 0..2
module cbb_rs_multimode #(
  parameter int P_DATA_WIDTH = 32,
  parameter int P_MODE       = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_flush,
  input  logic                    slv_i_valid,
  input  logic [P_DATA_WIDTH-1:0] slv_i_data,
  output logic                    slv_o_ready,
  output logic                    mst_o_valid,
  output logic [P_DATA_WIDTH-1:0] mst_o_data,
  input  logic                    mst_i_ready,
  output logic [1:0]              o_level
);

  if (P_MODE == 0) begin : g_bypass

    assign mst_o_valid = slv_i_valid;
    assign mst_o_data  = slv_i_data;
    assign slv_o_ready = mst_i_ready;
    assign o_level     = 2'd0;

  end else if (P_MODE == 1) begin : g_forward

    // en_p0 holds slv_o_ready low through reset and releases it on the
    // first edge afterwards.
    logic                    en_p0;
    logic                    vld_p1;
    logic [P_DATA_WIDTH-1:0] data_p1;
    logic                    s_xfer;
    logic                    m_xfer;

    assign mst_o_valid = vld_p1 & ~i_flush;
    assign mst_o_data  = data_p1;
    assign slv_o_ready = en_p0 & ~i_flush & (~vld_p1 | mst_i_ready);
    assign o_level     = {1'b0, vld_p1};

    assign s_xfer = slv_i_valid & slv_o_ready;
    assign m_xfer = mst_o_valid & mst_i_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        en_p0 <= 1'b0;
      end else begin
        en_p0 <= 1'b1;
      end
    end

    // stage p0 -> p1: output register
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        vld_p1 <= 1'b0;
      end else if (i_flush) begin
        vld_p1 <= 1'b0;
      end else if (s_xfer) begin
        vld_p1 <= 1'b1;
      end else if (m_xfer) begin
        vld_p1 <= 1'b0;
      end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        data_p1 <= '0;
      end else if (s_xfer) begin
        data_p1 <= slv_i_data;
      end
    end

  end else if (P_MODE == 2) begin : g_backward

    logic                    en_p0;
    logic                    skid_v_p1;
    logic [P_DATA_WIDTH-1:0] skid_data_p1;
    logic                    s_xfer;

    assign slv_o_ready = en_p0 & ~i_flush & ~skid_v_p1;
    assign mst_o_valid = en_p0 & ~i_flush & (slv_i_valid | skid_v_p1);
    // The pass-through leg is masked until the slice leaves reset so the
    // payload reads zero while held in reset.
    assign mst_o_data  = skid_v_p1 ? skid_data_p1
                                   : (en_p0 ? slv_i_data : '0);
    assign o_level     = {1'b0, skid_v_p1};

    assign s_xfer = slv_i_valid & slv_o_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        en_p0 <= 1'b0;
      end else begin
        en_p0 <= 1'b1;
      end
    end

    // stage p0 -> p1: skid register, filled only when the beat cannot pass
    // straight through; while full the skid is the only output source.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        skid_v_p1 <= 1'b0;
      end else if (i_flush) begin
        skid_v_p1 <= 1'b0;
      end else if (skid_v_p1) begin
        if (mst_i_ready) begin
          skid_v_p1 <= 1'b0;
        end
      end else if (s_xfer && !mst_i_ready) begin
        skid_v_p1 <= 1'b1;
      end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        skid_data_p1 <= '0;
      end else if (s_xfer && !mst_i_ready) begin
        skid_data_p1 <= slv_i_data;
      end
    end

  end else if (P_MODE == 3) begin : g_full

    logic                    en_p0;
    logic [P_DATA_WIDTH-1:0] mem_p1 [2];
    logic                    wr_ptr_p1;
    logic                    rd_ptr_p1;
    logic [1:0]              cnt_p1;
    logic                    push;
    logic                    pop;

    // Both handshake outputs decode registered state; the flush gate is the
    // only combinational term.
    assign slv_o_ready = en_p0 & ~i_flush & (cnt_p1 != 2'd2);
    assign mst_o_valid = ~i_flush & (cnt_p1 != 2'd0);
    assign mst_o_data  = mem_p1[rd_ptr_p1];
    assign o_level     = cnt_p1;

    assign push = slv_i_valid & slv_o_ready;
    assign pop  = mst_o_valid & mst_i_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        en_p0 <= 1'b0;
      end else begin
        en_p0 <= 1'b1;
      end
    end

    // stage p0 -> p1: pointer and occupancy update; push and pop together
    // leave the count unchanged while both pointers advance.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        wr_ptr_p1 <= 1'b0;
        rd_ptr_p1 <= 1'b0;
        cnt_p1    <= 2'd0;
      end else if (i_flush) begin
        wr_ptr_p1 <= 1'b0;
        rd_ptr_p1 <= 1'b0;
        cnt_p1    <= 2'd0;
      end else begin
        if (push) begin
          wr_ptr_p1 <= ~wr_ptr_p1;
        end
        if (pop) begin
          rd_ptr_p1 <= ~rd_ptr_p1;
        end
        case ({push, pop})
          2'b10:   cnt_p1 <= cnt_p1 + 2'd1;
          2'b01:   cnt_p1 <= cnt_p1 - 2'd1;
          default: cnt_p1 <= cnt_p1;
        endcase
      end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        mem_p1[0] <= '0;
        mem_p1[1] <= '0;
      end else if (push) begin
        mem_p1[wr_ptr_p1] <= slv_i_data;
      end
    end

  end else begin : g_bad_mode

    $error("cbb_rs_multimode: P_MODE must be 0, 1, 2 or 3");

  end

endmodule

// File: tb/tb_cbb_rs_multimode.sv
// tb_cbb_rs_multimode
//   Directed and randomised checks of all four slice modes. One instance per
//   mode shares clock and reset; each has its own handshake and flush inputs.
module tb_cbb_rs_multimode;

  logic        clk;
  logic        rst;
  logic        flush   [4];
  logic        s_valid [4];
  logic [31:0] s_data  [4];
  logic        s_ready [4];
  logic        m_valid [4];
  logic [31:0] m_data  [4];
  logic        m_ready [4];
  logic [1:0]  lvl     [4];

  int checks   = 0;
  int failures = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    cbb_rs_multimode #(
      .P_DATA_WIDTH(32),
      .P_MODE      (g)
    ) u_dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_flush    (flush[g]),
      .slv_i_valid(s_valid[g]),
      .slv_i_data (s_data[g]),
      .slv_o_ready(s_ready[g]),
      .mst_o_valid(m_valid[g]),
      .mst_o_data (m_data[g]),
      .mst_i_ready(m_ready[g]),
      .o_level    (lvl[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the
  // falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic run_random(input int m);
    logic [31:0] q[$];
    int          got;
    int          sent;
    int          cyc;
    logic        prev_hold;
    logic [31:0] prev_data;
    logic        s_x;
    logic        m_x;
    got       = 0;
    sent      = 0;
    cyc       = 0;
    prev_hold = 1'b0;
    prev_data = '0;
    s_valid[m] = 1'b0;
    m_ready[m] = 1'b0;
    while (got < 200 && cyc < 5000) begin
      smp();
      if (prev_hold) begin
        check_eq($sformatf("m%0d_hold_vld", m), 32'(m_valid[m]), 32'd1);
        check_eq($sformatf("m%0d_hold_data", m), m_data[m], prev_data);
      end
      s_x = s_valid[m] && s_ready[m];
      m_x = m_valid[m] && m_ready[m];
      if (s_x) q.push_back(s_data[m]);
      if (m_x) begin
        check_eq($sformatf("m%0d_pop_has_beat", m), 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          check_eq($sformatf("m%0d_order", m), m_data[m], q.pop_front());
          got++;
        end
      end
      prev_hold = m_valid[m] && !m_ready[m];
      prev_data = m_data[m];
      step();
      if (!s_valid[m] || s_x) begin
        if (sent < 200 && $urandom_range(0, 99) < 60) begin
          s_valid[m] = 1'b1;
          s_data[m]  = (32'(sent) << 16) | 32'($urandom_range(0, 65535));
          sent++;
        end else begin
          s_valid[m] = 1'b0;
        end
      end
      m_ready[m] = ($urandom_range(0, 99) < 70);
      cyc++;
    end
    check_eq($sformatf("m%0d_rand_beats", m), 32'(got), 32'd200);
    check_eq($sformatf("m%0d_rand_leftover", m), 32'(q.size()), 32'd0);
    s_valid[m] = 1'b0;
    m_ready[m] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      flush[i]   = 1'b0;
      s_valid[i] = 1'b0;
      s_data[i]  = '0;
      m_ready[i] = 1'b0;
    end

    // reset values
    smp();
    for (int m = 1; m < 4; m++) begin
      check_eq($sformatf("m%0d_rst_vld", m), 32'(m_valid[m]), 32'd0);
      check_eq($sformatf("m%0d_rst_data", m), m_data[m], 32'd0);
      check_eq($sformatf("m%0d_rst_lvl", m), 32'(lvl[m]), 32'd0);
      check_eq($sformatf("m%0d_rst_rdy", m), 32'(s_ready[m]), 32'd0);
    end
    step();
    rst = 1'b0;
    smp();
    for (int m = 1; m < 4; m++)
      check_eq($sformatf("m%0d_rdy_before_edge", m), 32'(s_ready[m]), 32'd0);
    step();
    smp();
    for (int m = 1; m < 4; m++)
      check_eq($sformatf("m%0d_rdy_after_edge", m), 32'(s_ready[m]), 32'd1);

    // mode 0: wires, flush ignored
    step();
    s_valid[0] = 1'b1; s_data[0] = 32'h55; m_ready[0] = 1'b1; flush[0] = 1'b1;
    smp();
    check_eq("m0_vld", 32'(m_valid[0]), 32'd1);
    check_eq("m0_data", m_data[0], 32'h55);
    check_eq("m0_rdy", 32'(s_ready[0]), 32'd1);
    check_eq("m0_lvl", 32'(lvl[0]), 32'd0);
    step();
    m_ready[0] = 1'b0; flush[0] = 1'b0;
    smp();
    check_eq("m0_rdy_low", 32'(s_ready[0]), 32'd0);
    step();
    s_valid[0] = 1'b0;

    // mode 1: single beat held under backpressure
    s_valid[1] = 1'b1; s_data[1] = 32'hDEADBEEF; m_ready[1] = 1'b0;
    smp();
    check_eq("m1_rdy_empty", 32'(s_ready[1]), 32'd1);
    check_eq("m1_vld_c0", 32'(m_valid[1]), 32'd0);
    step();
    s_valid[1] = 1'b0;
    smp();
    check_eq("m1_vld_c1", 32'(m_valid[1]), 32'd1);
    check_eq("m1_data_c1", m_data[1], 32'hDEADBEEF);
    check_eq("m1_rdy_held", 32'(s_ready[1]), 32'd0);
    check_eq("m1_lvl_c1", 32'(lvl[1]), 32'd1);
    step();
    smp();
    check_eq("m1_vld_c2", 32'(m_valid[1]), 32'd1);
    check_eq("m1_data_c2", m_data[1], 32'hDEADBEEF);
    step();
    m_ready[1] = 1'b1;
    smp();
    check_eq("m1_vld_rdy", 32'(m_valid[1]), 32'd1);
    check_eq("m1_rdy_comb", 32'(s_ready[1]), 32'd1);
    step();
    smp();
    check_eq("m1_vld_after", 32'(m_valid[1]), 32'd0);
    check_eq("m1_lvl_after", 32'(lvl[1]), 32'd0);

    // mode 2: skid capture of 0x2
    step();
    m_ready[2] = 1'b1; s_valid[2] = 1'b1; s_data[2] = 32'h1;
    smp();
    check_eq("m2_vld_1", 32'(m_valid[2]), 32'd1);
    check_eq("m2_data_1", m_data[2], 32'h1);
    check_eq("m2_lvl_1", 32'(lvl[2]), 32'd0);
    step();
    s_data[2] = 32'h2; m_ready[2] = 1'b0;
    smp();
    check_eq("m2_data_2", m_data[2], 32'h2);
    check_eq("m2_rdy_2", 32'(s_ready[2]), 32'd1);
    step();
    s_data[2] = 32'h3; m_ready[2] = 1'b1;
    smp();
    check_eq("m2_rdy_skid", 32'(s_ready[2]), 32'd0);
    check_eq("m2_lvl_skid", 32'(lvl[2]), 32'd1);
    check_eq("m2_data_skid", m_data[2], 32'h2);
    check_eq("m2_vld_skid", 32'(m_valid[2]), 32'd1);
    step();
    smp();
    check_eq("m2_rdy_3", 32'(s_ready[2]), 32'd1);
    check_eq("m2_data_3", m_data[2], 32'h3);
    check_eq("m2_lvl_3", 32'(lvl[2]), 32'd0);
    step();
    s_valid[2] = 1'b0;
    smp();
    check_eq("m2_vld_end", 32'(m_valid[2]), 32'd0);

    // mode 3: fill to two, third beat held upstream
    step();
    m_ready[3] = 1'b0; s_valid[3] = 1'b1; s_data[3] = 32'hA;
    smp();
    check_eq("m3_rdy_0", 32'(s_ready[3]), 32'd1);
    check_eq("m3_vld_0", 32'(m_valid[3]), 32'd0);
    step();
    s_data[3] = 32'hB;
    smp();
    check_eq("m3_lvl_1", 32'(lvl[3]), 32'd1);
    check_eq("m3_data_1", m_data[3], 32'hA);
    step();
    s_data[3] = 32'hC;
    smp();
    check_eq("m3_lvl_2", 32'(lvl[3]), 32'd2);
    check_eq("m3_rdy_full", 32'(s_ready[3]), 32'd0);
    step();
    smp();
    check_eq("m3_lvl_2b", 32'(lvl[3]), 32'd2);
    step();
    m_ready[3] = 1'b1;
    smp();
    check_eq("m3_out_a", m_data[3], 32'hA);
    check_eq("m3_rdy_a", 32'(s_ready[3]), 32'd0);
    step();
    smp();
    check_eq("m3_out_b", m_data[3], 32'hB);
    check_eq("m3_lvl_b", 32'(lvl[3]), 32'd1);
    check_eq("m3_rdy_b", 32'(s_ready[3]), 32'd1);
    step();
    s_valid[3] = 1'b0;
    smp();
    check_eq("m3_out_c", m_data[3], 32'hC);
    check_eq("m3_vld_c", 32'(m_valid[3]), 32'd1);
    check_eq("m3_lvl_c", 32'(lvl[3]), 32'd1);
    step();
    smp();
    check_eq("m3_vld_end", 32'(m_valid[3]), 32'd0);
    check_eq("m3_lvl_end", 32'(lvl[3]), 32'd0);

    // mode 3: flush with two stored beats
    step();
    m_ready[3] = 1'b0; s_valid[3] = 1'b1; s_data[3] = 32'h11;
    step();
    s_data[3] = 32'h22;
    step();
    s_valid[3] = 1'b0;
    smp();
    check_eq("m3f_lvl_pre", 32'(lvl[3]), 32'd2);
    step();
    flush[3] = 1'b1; m_ready[3] = 1'b1;
    smp();
    check_eq("m3f_vld_flush", 32'(m_valid[3]), 32'd0);
    check_eq("m3f_rdy_flush", 32'(s_ready[3]), 32'd0);
    step();
    flush[3] = 1'b0;
    smp();
    check_eq("m3f_lvl_post", 32'(lvl[3]), 32'd0);
    check_eq("m3f_vld_post", 32'(m_valid[3]), 32'd0);
    check_eq("m3f_rdy_post", 32'(s_ready[3]), 32'd1);

    // reset mid-stream with one beat stored in modes 1-3
    step();
    for (int m = 1; m < 4; m++) begin
      m_ready[m] = 1'b0; s_valid[m] = 1'b1; s_data[m] = 32'h100 + 32'(m);
    end
    step();
    for (int m = 1; m < 4; m++) s_valid[m] = 1'b0;
    smp();
    for (int m = 1; m < 4; m++)
      check_eq($sformatf("m%0d_lvl_prerst", m), 32'(lvl[m]), 32'd1);
    rst = 1'b1;
    #1;
    for (int m = 1; m < 4; m++) begin
      check_eq($sformatf("m%0d_arst_vld", m), 32'(m_valid[m]), 32'd0);
      check_eq($sformatf("m%0d_arst_lvl", m), 32'(lvl[m]), 32'd0);
      check_eq($sformatf("m%0d_arst_rdy", m), 32'(s_ready[m]), 32'd0);
      check_eq($sformatf("m%0d_arst_data", m), m_data[m], 32'd0);
    end
    step();
    rst = 1'b0;
    smp();
    for (int m = 1; m < 4; m++)
      check_eq($sformatf("m%0d_arst_rdy_rel", m), 32'(s_ready[m]), 32'd0);
    step();
    smp();
    for (int m = 1; m < 4; m++) begin
      check_eq($sformatf("m%0d_arst_rdy_up", m), 32'(s_ready[m]), 32'd1);
      check_eq($sformatf("m%0d_arst_vld_up", m), 32'(m_valid[m]), 32'd0);
    end

    // randomised scoreboard per mode
    for (int m = 0; m < 4; m++) run_random(m);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
